// File: rtl/sram_arbiter_if.sv
// Bundled request/response and SRAM command signals for sram_arbiter.
// slave = arbiter side, master = requesters plus SRAM model side.
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [3:0]            d_be;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  logic                  HSEL;
  logic                  HWRITE;
  logic [3:0]            HBE;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADY;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, HRDATA, HREADY,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           HSEL, HWRITE, HBE, HADDR, HWDATA
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, HRDATA, HREADY,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           HSEL, HWRITE, HBE, HADDR, HWDATA
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported SRAM.
// Define SRAM_ARB_RR_EN for round-robin tie breaking; default is fixed data priority.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input logic          HCLK,
  input logic          HRESETn,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic                  owner_d_reg;
  logic                  hsel_reg;
  logic                  hwrite_reg;
  logic [3:0]            hbe_reg;
  logic [ADDR_WIDTH-1:0] haddr_reg;
  logic [31:0]           hwdata_reg;

  logic                  resp_done;
  logic                  d_wins;
  logic                  grant_d;
  logic                  grant_i;

  assign resp_done = (state_reg == RESP) && bus.HREADY;

`ifdef SRAM_ARB_RR_EN
  // Cleared to "instruction last" so the first tie after reset goes to data.
  logic last_d_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_d_reg <= 1'b0;
    end else if (grant_d || grant_i) begin
      last_d_reg <= grant_d;
    end
  end

  assign d_wins = !bus.i_req || !last_d_reg;
`else
  assign d_wins = 1'b1;
`endif

  // Grants and completion pulses; HRESETn gating keeps them low while reset is held.
  always_comb begin
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rvalid = 1'b0;
    state_next   = state_reg;
    case (state_reg)
      IDLE: begin
        grant_d = HRESETn && bus.d_req && d_wins;
        grant_i = HRESETn && bus.i_req && !grant_d;
        if (grant_d || grant_i) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        if (resp_done) begin
          bus.d_rvalid = HRESETn && owner_d_reg;
          bus.i_rvalid = HRESETn && !owner_d_reg;
          grant_d      = HRESETn && bus.d_req && d_wins;
          grant_i      = HRESETn && bus.i_req && !grant_d;
          state_next   = (grant_d || grant_i) ? ACCESS : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Command registers load on the grant cycle and are presented during ACCESS.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_d_reg <= 1'b1;
      hsel_reg    <= 1'b0;
      hwrite_reg  <= 1'b0;
      hbe_reg     <= 4'b0000;
      haddr_reg   <= '0;
      hwdata_reg  <= 32'h0;
    end else begin
      hsel_reg <= grant_d || grant_i;
      if (grant_d) begin
        owner_d_reg <= 1'b1;
        hwrite_reg  <= bus.d_we;
        hbe_reg     <= bus.d_be;
        haddr_reg   <= bus.d_addr;
        hwdata_reg  <= bus.d_wdata;
      end else if (grant_i) begin
        owner_d_reg <= 1'b0;
        hwrite_reg  <= 1'b0;
        hbe_reg     <= 4'b1111;
        haddr_reg   <= bus.i_addr;
        hwdata_reg  <= 32'h0;
      end
    end
  end

  assign bus.i_gnt   = grant_i;
  assign bus.d_gnt   = grant_d;
  assign bus.i_rdata = bus.HRDATA;
  assign bus.d_rdata = bus.HRDATA;
  assign bus.HSEL    = hsel_reg;
  assign bus.HWRITE  = hwrite_reg;
  assign bus.HBE     = hbe_reg;
  assign bus.HADDR   = haddr_reg;
  assign bus.HWDATA  = hwdata_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a byte-enable SRAM model (word n resets to C0DE_nnnn).
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESETn;
  int   checks = 0;
  int   failures = 0;

  sram_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  sram_arbiter #(.ADDR_WIDTH(32)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  logic [31:0] mem [0:1023];
  logic [31:0] hrdata_reg;
  logic        hready;
  logic [9:0]  model_idx;

  assign bus.HRDATA = hrdata_reg;
  assign bus.HREADY = hready;

  initial begin
    for (int n = 0; n < 1024; n++) mem[n] = {16'hC0DE, 16'(n)};
  end

  // Read data returns the word as it was before any write in the same access.
  always @(posedge HCLK) begin
    if (bus.HSEL) begin
      model_idx = bus.HADDR[11:2];
      hrdata_reg <= mem[model_idx];
      if (bus.HWRITE) begin
        for (int b = 0; b < 4; b++)
          if (bus.HBE[b]) mem[model_idx][8*b +: 8] = bus.HWDATA[8*b +: 8];
      end
    end
  end

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    hready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESETn = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    @(negedge HCLK); #1;
    checks++; if (bus.HSEL !== 1'b0) begin failures++; $display("FAIL rst_hsel got=%b want=0", bus.HSEL); end
    checks++; if (bus.HWRITE !== 1'b0) begin failures++; $display("FAIL rst_hwrite got=%b want=0", bus.HWRITE); end
    checks++; if (bus.HBE !== 4'h0) begin failures++; $display("FAIL rst_hbe got=%h want=0", bus.HBE); end
    checks++; if (bus.HADDR !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%h want=0", bus.HADDR); end
    checks++; if (bus.HWDATA !== 32'h0) begin failures++; $display("FAIL rst_hwdata got=%h want=0", bus.HWDATA); end
    checks++; if (bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=i%b d%b want=0", bus.i_gnt, bus.d_gnt); end
    checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=i%b d%b want=0", bus.i_rvalid, bus.d_rvalid); end
    idle_inputs();
    @(negedge HCLK);
    HRESETn = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_instr_read(input logic [31:0] addr, input logic [31:0] exp_data);
    @(negedge HCLK);
    bus.i_req = 1'b1; bus.i_addr = addr; #1;
    checks++; if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin failures++; $display("FAIL i_gnt got=i%b d%b want=i1 d0", bus.i_gnt, bus.d_gnt); end
    @(negedge HCLK);
    bus.i_req = 1'b0; #1;
    checks++; if (bus.HSEL !== 1'b1 || bus.HADDR !== addr) begin failures++; $display("FAIL i_cmd got=sel%b addr%h want=sel1 addr%h", bus.HSEL, bus.HADDR, addr); end
    checks++; if ({bus.HWRITE, bus.HBE} !== 5'b01111 || bus.HWDATA !== 32'h0) begin failures++; $display("FAIL i_cmd_fields got=we%b be%h wd%h want=we0 beF wd0", bus.HWRITE, bus.HBE, bus.HWDATA); end
    checks++; if (bus.i_rvalid !== 1'b0) begin failures++; $display("FAIL i_rvalid_early got=%b want=0", bus.i_rvalid); end
    @(negedge HCLK); #1;
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== exp_data) begin failures++; $display("FAIL i_resp got=v%b %h want=v1 %h", bus.i_rvalid, bus.i_rdata, exp_data); end
    checks++; if (bus.d_rvalid !== 1'b0 || bus.HSEL !== 1'b0) begin failures++; $display("FAIL i_resp_side got=dv%b sel%b want=0 0", bus.d_rvalid, bus.HSEL); end
    $display("instr read addr=%h data=%h", addr, bus.i_rdata);
  endtask

  task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
    @(negedge HCLK);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata; #1;
    checks++; if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0) begin failures++; $display("FAIL d_gnt got=d%b i%b want=d1 i0", bus.d_gnt, bus.i_gnt); end
    @(negedge HCLK);
    bus.d_req = 1'b0; #1;
    checks++; if ({bus.HSEL, bus.HWRITE, bus.HBE} !== {1'b1, we, be} || bus.HADDR !== addr || bus.HWDATA !== wdata) begin
      failures++; $display("FAIL d_cmd got=sel%b we%b be%h a%h wd%h want=sel1 we%b be%h a%h wd%h",
        bus.HSEL, bus.HWRITE, bus.HBE, bus.HADDR, bus.HWDATA, we, be, addr, wdata); end
    @(negedge HCLK); #1;
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== exp_rdata) begin failures++; $display("FAIL d_resp got=v%b %h want=v1 %h", bus.d_rvalid, bus.d_rdata, exp_rdata); end
    checks++; if (bus.i_rvalid !== 1'b0) begin failures++; $display("FAIL d_resp_iv got=%b want=0", bus.i_rvalid); end
    $display("data %s addr=%h be=%h wdata=%h rdata=%h", we ? "write" : "read", addr, be, wdata, bus.d_rdata);
  endtask

  task automatic test_data_write();
    do_data(1'b1, 4'hF, 32'h200, 32'h11223344, 32'hC0DE0080);
    do_data(1'b1, 4'h3, 32'h200, 32'hAABBCCDD, 32'h11223344);
    do_data(1'b0, 4'h0, 32'h200, 32'h0,        32'h1122CCDD);
  endtask

  task automatic test_tie();
    logic exp_d, exp_i, exp_dv, exp_iv;
    @(negedge HCLK); HRESETn = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge HCLK);
      bus.i_req = 1'b1; bus.i_addr = 32'h300;
      bus.d_req = 1'b1; bus.d_addr = 32'h400; bus.d_we = 1'b0; bus.d_be = 4'hF; #1;
      exp_d  = (k % 2 == 0) && (!RR || (k / 2) % 2 == 0);
      exp_i  = (k % 2 == 0) && RR && (k / 2) % 2 == 1;
      exp_dv = (k >= 2) && (k % 2 == 0) && (!RR || ((k - 2) / 2) % 2 == 0);
      exp_iv = (k >= 2) && (k % 2 == 0) && RR && ((k - 2) / 2) % 2 == 1;
      checks++; if (bus.d_gnt !== exp_d || bus.i_gnt !== exp_i) begin failures++; $display("FAIL tie_gnt[%0d] got=d%b i%b want=d%b i%b", k, bus.d_gnt, bus.i_gnt, exp_d, exp_i); end
      checks++; if (bus.d_rvalid !== exp_dv || bus.i_rvalid !== exp_iv) begin failures++; $display("FAIL tie_rvalid[%0d] got=d%b i%b want=d%b i%b", k, bus.d_rvalid, bus.i_rvalid, exp_dv, exp_iv); end
      $display("tie cycle %0d: d_gnt=%b i_gnt=%b", k, bus.d_gnt, bus.i_gnt);
    end
    @(negedge HCLK); idle_inputs();
    @(negedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic test_stall();
    @(negedge HCLK);
    bus.i_req = 1'b1; bus.i_addr = 32'h104; #1;
    checks++; if (bus.i_gnt !== 1'b1) begin failures++; $display("FAIL stall_gnt got=%b want=1", bus.i_gnt); end
    @(negedge HCLK);
    bus.i_req = 1'b0; hready = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h108; #1;
    checks++; if (bus.HSEL !== 1'b1 || bus.d_gnt !== 1'b0) begin failures++; $display("FAIL stall_access got=sel%b dg%b want=sel1 dg0", bus.HSEL, bus.d_gnt); end
    for (int s = 0; s < 3; s++) begin
      @(negedge HCLK); #1;
      checks++; if (bus.i_rvalid !== 1'b0 || bus.d_gnt !== 1'b0 || bus.HSEL !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d] got=iv%b dg%b sel%b want=0 0 0", s, bus.i_rvalid, bus.d_gnt, bus.HSEL); end
    end
    @(negedge HCLK);
    hready = 1'b1; #1;
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hC0DE0041) begin failures++; $display("FAIL stall_resp got=v%b %h want=v1 c0de0041", bus.i_rvalid, bus.i_rdata); end
    checks++; if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0) begin failures++; $display("FAIL b2b_gnt got=d%b i%b want=d1 i0", bus.d_gnt, bus.i_gnt); end
    @(negedge HCLK);
    bus.d_req = 1'b0; #1;
    checks++; if (bus.HSEL !== 1'b1 || bus.HADDR !== 32'h108) begin failures++; $display("FAIL b2b_cmd got=sel%b a%h want=sel1 a00000108", bus.HSEL, bus.HADDR); end
    @(negedge HCLK); #1;
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hC0DE0042) begin failures++; $display("FAIL b2b_resp got=v%b %h want=v1 c0de0042", bus.d_rvalid, bus.d_rdata); end
    $display("stall: instr then back-to-back data done");
  endtask

  task automatic test_reset_mid();
    @(negedge HCLK);
    bus.i_req = 1'b1; bus.i_addr = 32'h10C; #1;
    checks++; if (bus.i_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt got=%b want=1", bus.i_gnt); end
    @(negedge HCLK);
    bus.i_req = 1'b0; #1;
    checks++; if (bus.HSEL !== 1'b1) begin failures++; $display("FAIL rmid_access got=%b want=1", bus.HSEL); end
    HRESETn = 1'b0; #1;
    checks++; if (bus.HSEL !== 1'b0 || bus.HADDR !== 32'h0) begin failures++; $display("FAIL rmid_hsel got=sel%b a%h want=sel0 a0", bus.HSEL, bus.HADDR); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK); #1;
      checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_rvalid[%0d] got=i%b d%b want=0", c, bus.i_rvalid, bus.d_rvalid); end
    end
    $display("reset mid-access: dropped");
    test_instr_read(32'h10C, 32'hC0DE0043);
  endtask

  initial begin
    test_reset();
    test_instr_read(32'h100, 32'hC0DE0040);
    test_data_write();
    test_tie();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
